// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/grant/response, branch redirect
// and the instruction handshake toward decode. Suffixes are relative to the fetch unit.
interface fetch_unit_if;
    logic        imem_req_o;
    logic [15:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        branch_en_i;
    logic [31:0] branch_addr_i;
    logic        insn_valid_o;
    logic        insn_ready_i;
    logic [31:0] insn_o;
    logic [15:0] insn_pc_o;

    modport master (
        output imem_req_o, imem_addr_o, insn_valid_o, insn_o, insn_pc_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, branch_en_i, branch_addr_i, insn_ready_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o, insn_valid_o, insn_o, insn_pc_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i, branch_en_i, branch_addr_i, insn_ready_i
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, credit-limited memory requests with in-order responses,
// 2-entry instruction queue toward decode, and branch redirect with stale-response discard.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    fetch_unit_if.master bus
);
    typedef enum logic {BOOT, RUN} state_e;

    typedef struct packed {
        logic [31:0] insn;
        logic [15:0] pc;
    } entry_t;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [1:0]  out_cnt_q, out_cnt_d;
    logic [1:0]  drop_cnt_q, drop_cnt_d;
    logic [1:0]  q_cnt_q, q_cnt_d;
    logic [15:0] tag_q [2];
    logic [15:0] tag_d [2];
    entry_t      fifo_q [2];
    entry_t      fifo_d [2];

    logic req, insn_valid, grant, rsp, keep, pop;
    logic unused_addr_bits;

    assign unused_addr_bits = ^{bus.branch_addr_i[31:16], bus.branch_addr_i[1:0]};

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    // Credit rule: in-flight plus queued never exceeds the 2 queue slots.
    always_comb begin
        req        = (state_q == RUN) && !bus.branch_en_i &&
                     (({1'b0, out_cnt_q} + {1'b0, q_cnt_q}) < 3'd2);
        insn_valid = (q_cnt_q != 2'd0) && !bus.branch_en_i;
    end

    assign bus.imem_req_o   = req;
    assign bus.imem_addr_o  = pc_q;
    assign bus.insn_valid_o = insn_valid;
    assign bus.insn_o       = (q_cnt_q != 2'd0) ? fifo_q[0].insn : 32'h0;
    assign bus.insn_pc_o    = (q_cnt_q != 2'd0) ? fifo_q[0].pc   : 16'h0;

    assign grant = req && bus.imem_gnt_i;
    assign rsp   = bus.imem_rvalid_i && (out_cnt_q != 2'd0);
    assign keep  = rsp && (drop_cnt_q == 2'd0);
    assign pop   = insn_valid && bus.insn_ready_i;

    always_comb begin
        pc_d       = pc_q;
        out_cnt_d  = out_cnt_q + {1'b0, grant} - {1'b0, rsp};
        drop_cnt_d = drop_cnt_q;
        q_cnt_d    = q_cnt_q;
        tag_d      = tag_q;
        fifo_d     = fifo_q;

        if (rsp) begin
            tag_d[0] = tag_q[1];
        end
        if (grant) begin
            pc_d = pc_q + 16'(PC_STEP);
            if ((out_cnt_q == 2'd1) && !rsp) begin
                tag_d[1] = pc_q;
            end else begin
                tag_d[0] = pc_q;
            end
        end

        // Everything already in flight at a redirect becomes a return to discard.
        if (bus.branch_en_i) begin
            pc_d       = {bus.branch_addr_i[15:2], 2'b00};
            drop_cnt_d = out_cnt_q - {1'b0, rsp};
            q_cnt_d    = 2'd0;
        end else begin
            if (rsp && (drop_cnt_q != 2'd0)) begin
                drop_cnt_d = drop_cnt_q - 2'd1;
            end
            if (pop) begin
                fifo_d[0] = fifo_q[1];
                q_cnt_d   = q_cnt_q - 2'd1;
            end
            if (keep) begin
                if (q_cnt_d == 2'd0) begin
                    fifo_d[0] = {bus.imem_rdata_i, tag_q[0]};
                end else begin
                    fifo_d[1] = {bus.imem_rdata_i, tag_q[0]};
                end
                q_cnt_d = q_cnt_d + 2'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            pc_q       <= RESET_PC;
            out_cnt_q  <= 2'd0;
            drop_cnt_q <= 2'd0;
            q_cnt_q    <= 2'd0;
            tag_q      <= '{default: '0};
            fifo_q     <= '{default: '0};
        end else begin
            pc_q       <= pc_d;
            out_cnt_q  <= out_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            q_cnt_q    <= q_cnt_d;
            tag_q      <= tag_d;
            fifo_q     <= fifo_d;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based reference model plus a randomized in-order memory,
// with a second instance exercising PC wrap-around.
module tb_fetch_unit;
    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam logic [15:0] WRAP_PC  = 16'hFFFC;
    localparam int          STEP     = 4;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
        bit          stale;
    } fetch_t;

    typedef struct {
        logic [31:0] insn;
        logic [15:0] pc;
    } insn_t;

    typedef struct {
        logic [31:0] data;
        int          due;
    } mem_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    fetch_unit_if bus ();
    fetch_unit_if bus2 ();

    fetch_unit #(.RESET_PC(RESET_PC), .PC_STEP(STEP)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    fetch_unit #(.RESET_PC(WRAP_PC), .PC_STEP(STEP)) dutWrap (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus2)
    );

    always #5 clk = ~clk;

    int testCount = 0;
    int failCount = 0;
    int cycle     = 0;

    // Reference model: abstract PC, in-flight fetch list with stale marks, decode queue
    bit          mRun;
    logic [15:0] mPc;
    fetch_t      inflight[$];
    insn_t       fifo[$];
    mem_t        memQ[$];
    int          memLat;
    int          rvDelayPct;
    bit          spuriousEn;

    logic [15:0] wrapGrants[$];
    logic [15:0] wrapPcs[$];
    bit          wrapPend;
    logic [15:0] wrapPendAddr;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        testCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cycle);
        end
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst_n                = 1'b0;
        bus.imem_gnt_i       = 1'b0;
        bus.imem_rvalid_i    = 1'b0;
        bus.imem_rdata_i     = 32'h0;
        bus.branch_en_i      = 1'b0;
        bus.branch_addr_i    = 32'h0;
        bus.insn_ready_i     = 1'b0;
        bus2.imem_gnt_i      = 1'b0;
        bus2.imem_rvalid_i   = 1'b0;
        bus2.imem_rdata_i    = 32'h0;
        bus2.branch_en_i     = 1'b0;
        bus2.branch_addr_i   = 32'h0;
        bus2.insn_ready_i    = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rst_req",     32'(bus.imem_req_o),   32'h0);
        checkOutput("rst_addr",    32'(bus.imem_addr_o),  32'(RESET_PC));
        checkOutput("rst_valid",   32'(bus.insn_valid_o), 32'h0);
        checkOutput("rst_insn",    bus.insn_o,            32'h0);
        checkOutput("rst_insn_pc", 32'(bus.insn_pc_o),    32'h0);
        checkOutput("rst_wrap_addr", 32'(bus2.imem_addr_o), 32'(WRAP_PC));
        mRun     = 1'b0;
        mPc      = RESET_PC;
        inflight.delete();
        fifo.delete();
        memQ.delete();
        wrapPend = 1'b0;
        cycle++;
    endtask

    task automatic applyStimulus(input bit gnt, input bit rdy, input bit br, input logic [31:0] ba);
        bit          mReq, mValid, grant, rsp, rv;
        logic [31:0] rdata, mInsn;
        logic [15:0] mInsnPc;
        fetch_t      f;

        @(negedge clk);
        rst_n = 1'b1;
        rv    = 1'b0;
        rdata = $urandom;
        if (memQ.size() > 0) begin
            if ((memQ[0].due <= cycle) && ($urandom_range(0, 99) >= rvDelayPct)) begin
                rv    = 1'b1;
                rdata = memQ[0].data;
            end
        end else if (spuriousEn && ($urandom_range(0, 15) == 0)) begin
            rv = 1'b1;
        end
        bus.imem_gnt_i     = gnt;
        bus.imem_rvalid_i  = rv;
        bus.imem_rdata_i   = rdata;
        bus.branch_en_i    = br;
        bus.branch_addr_i  = ba;
        bus.insn_ready_i   = rdy;
        bus2.imem_gnt_i    = 1'b1;
        bus2.imem_rvalid_i = wrapPend;
        bus2.imem_rdata_i  = {16'hC0DE, wrapPendAddr};
        bus2.branch_en_i   = 1'b0;
        bus2.branch_addr_i = 32'h0;
        bus2.insn_ready_i  = 1'b1;
        #1;

        mReq    = mRun && !br && ((inflight.size() + fifo.size()) < 2);
        mValid  = (fifo.size() != 0) && !br;
        mInsn   = (fifo.size() != 0) ? fifo[0].insn : 32'h0;
        mInsnPc = (fifo.size() != 0) ? fifo[0].pc   : 16'h0;
        checkOutput("imem_req",   32'(bus.imem_req_o),   32'(mReq));
        checkOutput("imem_addr",  32'(bus.imem_addr_o),  32'(mPc));
        checkOutput("insn_valid", 32'(bus.insn_valid_o), 32'(mValid));
        checkOutput("insn",       bus.insn_o,            mInsn);
        checkOutput("insn_pc",    32'(bus.insn_pc_o),    32'(mInsnPc));

        grant = mReq && gnt;
        rsp   = rv && (inflight.size() > 0);
        if (rv && (memQ.size() > 0)) memQ.delete(0);

        if (br) begin
            if (rsp) inflight.delete(0);
            foreach (inflight[i]) inflight[i].stale = 1'b1;
            fifo.delete();
            mPc = {ba[15:2], 2'b00};
        end else begin
            if (mValid && rdy) fifo.delete(0);
            if (rsp) begin
                f = inflight[0];
                inflight.delete(0);
                if (!f.stale) fifo.push_back('{insn: f.data, pc: f.addr});
            end
            if (grant) begin
                f.addr  = mPc;
                f.data  = $urandom;
                f.stale = 1'b0;
                inflight.push_back(f);
                memQ.push_back('{data: f.data,
                                 due: cycle + ((memLat == 0) ? int'($urandom_range(1, 3)) : memLat)});
                mPc = mPc + 16'(STEP);
            end
        end
        mRun = 1'b1;

        if (bus2.insn_valid_o) wrapPcs.push_back(bus2.insn_pc_o);
        if (bus2.imem_req_o)   wrapGrants.push_back(bus2.imem_addr_o);
        wrapPend     = bus2.imem_req_o;
        wrapPendAddr = bus2.imem_addr_o;
        cycle++;
    endtask

    initial begin
        memLat     = 1;
        rvDelayPct = 0;
        spuriousEn = 1'b0;
        wrapPend   = 1'b0;
        wrapPendAddr = 16'h0;

        // Streaming with immediate grant and single-cycle memory
        resetDut();
        repeat (16) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);

        // Backpressure from reset: head must hold the word fetched from 0x0000
        resetDut();
        repeat (6) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("bp_req_dropped", 32'(bus.imem_req_o), 32'h0);
        checkOutput("bp_head_pc",     32'(bus.insn_pc_o),  32'h0);
        repeat (10) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);

        // Redirect with two fetches outstanding
        resetDut();
        memLat = 3;
        repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0123);
        memLat = 1;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("redir_addr", 32'(bus.imem_addr_o), 32'h0000_0120);
        repeat (10) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);

        // Redirect coinciding with a response and a pop
        resetDut();
        repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0040);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("redir_fifo_empty", 32'(bus.insn_valid_o), 32'h0);
        repeat (8) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);

        // Randomized traffic with variable latency, stray responses and occasional resets
        memLat     = 0;
        rvDelayPct = 30;
        spuriousEn = 1'b1;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                resetDut();
            end else begin
                applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                              $urandom_range(0, 11) == 0, $urandom);
            end
        end

        // Reset while traffic is in flight, then restart from RESET_PC
        memLat     = 1;
        rvDelayPct = 0;
        spuriousEn = 1'b0;
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        resetDut();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("boot_no_req", 32'(bus.imem_req_o), 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("first_req",      32'(bus.imem_req_o),  32'h1);
        checkOutput("first_req_addr", 32'(bus.imem_addr_o), 32'(RESET_PC));
        repeat (4) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);

        // PC wrap on the second instance
        checkOutput("wrap_grant_count", 32'(wrapGrants.size() >= 2), 32'h1);
        checkOutput("wrap_pc_count",    32'(wrapPcs.size() >= 2),    32'h1);
        if (wrapGrants.size() >= 2) begin
            checkOutput("wrap_req0", 32'(wrapGrants[0]), 32'h0000_FFFC);
            checkOutput("wrap_req1", 32'(wrapGrants[1]), 32'h0000_0000);
        end
        if (wrapPcs.size() >= 2) begin
            checkOutput("wrap_pc0", 32'(wrapPcs[0]), 32'h0000_FFFC);
            checkOutput("wrap_pc1", 32'(wrapPcs[1]), 32'h0000_0000);
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end
endmodule
